test_pattern_generator: RTL and testbench
=========================================

// Module: test_pattern_generator
// PURPOSE
//  Parametrised, multi-mode video test-pattern source. Sits directly behind
//  hvsync_generator: takes hpos/vpos/display_on/hsync/vsync, renders one of
//  six selectable or auto-cycling patterns (incl. frame-animated ones), and
//  drives registered, sync-aligned RGB to the display pins. Used for board
//  bring-up and monitor checks before the game logic is attached.
// PARAMETERS
//  POS_W           9    width of hpos/vpos
//  COLOR_BITS      1    bits per colour channel (1..POS_W); rgb = 3*COLOR_BITS
//  GRID_LOG2       3    grid line pitch = 2**GRID_LOG2 px (mode GRID)
//  CHECK_LOG2      4    checker square size = 2**CHECK_LOG2 px
//  BAR_SHIFT       5    colour bar width = 2**BAR_SHIFT px (8 bars, repeating)
//  FRAME_W         8    frame counter width (>= COLOR_BITS)
//  FRAMES_PER_MODE 120  dwell per mode in auto-cycle (1..2**16-1)
// PORTS
//  clk          in   1            pixel clock
//  reset        in   1            async, ACTIVE-LOW reset
//  hpos         in   POS_W        horizontal position from hvsync_generator
//  vpos         in   POS_W        vertical position from hvsync_generator
//  display_on   in   1            visible-area flag
//  hsync_in     in   1            raw hsync from hvsync_generator
//  vsync_in     in   1            raw vsync from hvsync_generator
//  mode_sel     in   3            requested mode (manual mode)
//  auto_cycle   in   1            1 = step through modes automatically
//  hsync        out  1            hsync_in delayed 1 cycle
//  vsync        out  1            vsync_in delayed 1 cycle
//  rgb          out  3*COLOR_BITS {b,g,r}, each COLOR_BITS wide, registered
//  mode_active  out  3            mode in effect for the current frame
//  frame_count  out  FRAME_W      frames since reset, wraps
// BEHAVIOUR
//  - Reset (reset==0, async assert, sync release): rgb=0, hsync=0, vsync=0,
//    mode_active=0, frame_count=0, dwell counter=0.
//  - Latency: exactly 1 clk from (hpos,vpos,display_on,syncs) to outputs;
//    syncs and rgb stay mutually aligned. display_on==0 -> rgb=0 next cycle.
//  - frame_start = (hpos==0 && vpos==0), one cycle per frame. On it:
//    frame_count+=1 (mod 2**FRAME_W); mode_active<=mode_next. The pixel
//    rendered in the frame_start cycle already uses mode_next and the
//    incremented count, so every pixel of a frame sees one mode/count.
//  - mode_next: manual (auto_cycle=0) -> mode_sel. Auto -> if dwell==
//    FRAMES_PER_MODE-1: dwell=0, mode=(mode==5)?0:mode+1; else dwell+=1,
//    mode held. Auto with reserved mode (6,7) active -> next step goes to 0.
//  - auto_cycle 0->1: cycling starts from current mode, dwell cleared at
//    the first auto frame_start. 1->0: mode_sel loads at next frame_start.
//  - mode_sel/auto_cycle changes mid-frame never alter the current frame.
//  - Modes (F = full-scale all-ones channel, 0 = zero):
//    0 GRID   r=F if hpos or vpos low GRID_LOG2 bits ==0; g=F if vpos[4];
//             b=F if hpos[4] (COLOR_BITS=1, GRID_LOG2=3: legacy test image)
//    1 BARS   idx=hpos[BAR_SHIFT+2:BAR_SHIFT]; r=F if idx[0],g idx[1],b idx[2]
//    2 CHECK  white if hpos[CHECK_LOG2]^vpos[CHECK_LOG2], else black
//    3 GRAD   r=hpos[POS_W-1 -:COLOR_BITS], g=vpos[POS_W-1 -:COLOR_BITS],
//             b=frame_count[COLOR_BITS-1:0]
//    4 SCROLL as CHECK with h=(hpos+frame_count) mod 2**POS_W
//    5 SOLID  white;   6,7 reserved -> black
//  - Arithmetic: unsigned, POS_W-bit wrap; no saturation anywhere.
// STRUCTURE
//  - Package test_pattern_pkg: mode localparams (MODE_GRID..MODE_SOLID,
//    MODE_LAST=5) and mode width constant.
//  - Sub-module pattern_mode_sequencer: frame_start detect, frame_count,
//    dwell counter, mode_next/mode_active. Top holds pixel mux + output regs.
// TESTING
//  1 reset low mid-frame -> all outputs 0 same cycle; after release first
//    frame_start gives frame_count=1, mode_active=mode_sel.
//  2 defaults, mode 0, pixel (8,0) display_on=1 -> rgb=3'b001 one cycle
//    later; (16,16) -> 3'b111; display_on=0 -> 3'b000; hsync lags by 1.
//  3 manual, mode_sel 2->5 at vpos=100 -> frame unchanged; next frame
//    (0,0) renders white, mode_active=5.
//  4 auto_cycle=1, FRAMES_PER_MODE=2, start mode 4 -> modes 4,4,5,5,0,0
//    over six frames; mode_sel ignored.
//  5 FRAME_W=8: 256 frame_starts -> frame_count wraps 255->0; SCROLL
//    checker at vpos=0 offset moves by 1 px per frame.
//  6 COLOR_BITS=3, mode 3, hpos=0x1C0, vpos=0x040, frame_count=5
//    -> r=3'b111, g=3'b001, b=3'b101.

Source files
------------

// File: rtl/test_pattern_pkg.sv
// Mode encodings shared by the test-pattern generator and its mode sequencer.
// Mode values 6 and 7 are reserved and render black.
package test_pattern_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_GRID   = 3'd0;
    localparam logic [MODE_W-1:0] MODE_BARS   = 3'd1;
    localparam logic [MODE_W-1:0] MODE_CHECK  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_GRAD   = 3'd3;
    localparam logic [MODE_W-1:0] MODE_SCROLL = 3'd4;
    localparam logic [MODE_W-1:0] MODE_SOLID  = 3'd5;
    localparam logic [MODE_W-1:0] MODE_LAST   = MODE_SOLID;

endpackage

// File: rtl/pattern_mode_sequencer.sv
// Per-frame mode/frame-count sequencer: frame_start detect, manual or auto-cycling mode.
// mode_cur/count_cur are combinational and already reflect the frame_start update; no backpressure.
module pattern_mode_sequencer
    import test_pattern_pkg::*;
#(
    parameter int POS_W           = 9,
    parameter int FRAME_W         = 8,
    parameter int FRAMES_PER_MODE = 120
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [POS_W-1:0]   hpos,
    input  logic [POS_W-1:0]   vpos,
    input  logic [MODE_W-1:0]  mode_sel,
    input  logic               auto_cycle,
    output logic [MODE_W-1:0]  mode_cur,
    output logic [FRAME_W-1:0] count_cur,
    output logic [MODE_W-1:0]  mode_active,
    output logic [FRAME_W-1:0] frame_count
);

    localparam logic [15:0] DWELL_LAST = 16'(FRAMES_PER_MODE - 1);

    logic               frame_start;
    logic [15:0]        dwell;
    logic [15:0]        dwell_next;
    logic [MODE_W-1:0]  mode_next;
    logic [FRAME_W-1:0] count_next;
    logic               cycling;

    always_comb begin
        frame_start = (hpos == '0) && (vpos == '0);
        count_next  = frame_count + FRAME_W'(1);
        mode_next   = mode_sel;
        dwell_next  = '0;
        if (auto_cycle) begin
            // First auto frame keeps the current mode and restarts the dwell count.
            if (mode_active > MODE_LAST) begin
                mode_next = MODE_GRID;
            end else if (!cycling) begin
                mode_next = mode_active;
            end else if (dwell == DWELL_LAST) begin
                mode_next = (mode_active == MODE_LAST) ? MODE_GRID : mode_active + 3'd1;
            end else begin
                mode_next  = mode_active;
                dwell_next = dwell + 16'd1;
            end
        end
        mode_cur  = frame_start ? mode_next  : mode_active;
        count_cur = frame_start ? count_next : frame_count;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_active <= '0;
            frame_count <= '0;
            dwell       <= '0;
            cycling     <= 1'b0;
        end else if (frame_start) begin
            mode_active <= mode_next;
            frame_count <= count_next;
            dwell       <= dwell_next;
            cycling     <= auto_cycle;
        end
    end

endmodule

// File: rtl/test_pattern_generator.sv
// Multi-mode video test-pattern source behind hvsync_generator; renders {b,g,r} per pixel.
// Latency 1 clk for rgb and syncs (kept aligned); no backpressure, one pixel per clock.
module test_pattern_generator
    import test_pattern_pkg::*;
#(
    parameter int POS_W           = 9,
    parameter int COLOR_BITS      = 1,
    parameter int GRID_LOG2       = 3,
    parameter int CHECK_LOG2      = 4,
    parameter int BAR_SHIFT       = 5,
    parameter int FRAME_W         = 8,
    parameter int FRAMES_PER_MODE = 120
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [POS_W-1:0]        hpos,
    input  logic [POS_W-1:0]        vpos,
    input  logic                    display_on,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic [2:0]              mode_sel,
    input  logic                    auto_cycle,
    output logic                    hsync,
    output logic                    vsync,
    output logic [3*COLOR_BITS-1:0] rgb,
    output logic [2:0]              mode_active,
    output logic [FRAME_W-1:0]      frame_count
);

    logic [MODE_W-1:0]     mode_cur;
    logic [FRAME_W-1:0]    count_cur;
    logic [POS_W-1:0]      h_scroll;
    logic [2:0]            bar_idx;
    logic [COLOR_BITS-1:0] r;
    logic [COLOR_BITS-1:0] g;
    logic [COLOR_BITS-1:0] b;

    pattern_mode_sequencer #(
        .POS_W          (POS_W),
        .FRAME_W        (FRAME_W),
        .FRAMES_PER_MODE(FRAMES_PER_MODE)
    ) u_seq (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .mode_sel   (mode_sel),
        .auto_cycle (auto_cycle),
        .mode_cur   (mode_cur),
        .count_cur  (count_cur),
        .mode_active(mode_active),
        .frame_count(frame_count)
    );

    always_comb begin
        r        = '0;
        g        = '0;
        b        = '0;
        h_scroll = hpos + POS_W'(count_cur);
        bar_idx  = hpos[BAR_SHIFT+2:BAR_SHIFT];
        case (mode_cur)
            MODE_GRID: begin
                r = {COLOR_BITS{(hpos[GRID_LOG2-1:0] == '0) || (vpos[GRID_LOG2-1:0] == '0)}};
                g = {COLOR_BITS{vpos[4]}};
                b = {COLOR_BITS{hpos[4]}};
            end
            MODE_BARS: begin
                r = {COLOR_BITS{bar_idx[0]}};
                g = {COLOR_BITS{bar_idx[1]}};
                b = {COLOR_BITS{bar_idx[2]}};
            end
            MODE_CHECK: begin
                r = {COLOR_BITS{hpos[CHECK_LOG2] ^ vpos[CHECK_LOG2]}};
                g = r;
                b = r;
            end
            MODE_GRAD: begin
                r = hpos[POS_W-1 -: COLOR_BITS];
                g = vpos[POS_W-1 -: COLOR_BITS];
                b = count_cur[COLOR_BITS-1:0];
            end
            MODE_SCROLL: begin
                r = {COLOR_BITS{h_scroll[CHECK_LOG2] ^ vpos[CHECK_LOG2]}};
                g = r;
                b = r;
            end
            MODE_SOLID: begin
                r = '1;
                g = '1;
                b = '1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync <= 1'b0;
            vsync <= 1'b0;
            rgb   <= '0;
        end else begin
            hsync <= hsync_in;
            vsync <= vsync_in;
            rgb   <= display_on ? {b, g, r} : '0;
        end
    end

endmodule

// File: tb/tb_test_pattern_generator.sv
// Bench: two generator configurations driven in lockstep, checked against a
// per-frame reference model of mode schedule, frame count and pixel colours.
module tb_test_pattern_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [8:0] hpos, vpos;
    logic       display_on, hsync_in, vsync_in, auto_cycle;
    logic [2:0] mode_sel;

    logic       hsync_a, vsync_a;
    logic [2:0] rgb_a, mode_a;
    logic [7:0] fc_a;
    logic       hsync_b, vsync_b;
    logic [8:0] rgb_b;
    logic [2:0] mode_b;
    logic [7:0] fc_b;

    test_pattern_generator dut_a (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .mode_sel(mode_sel), .auto_cycle(auto_cycle),
        .hsync(hsync_a), .vsync(vsync_a), .rgb(rgb_a), .mode_active(mode_a), .frame_count(fc_a)
    );

    test_pattern_generator #(.COLOR_BITS(3), .FRAMES_PER_MODE(2)) dut_b (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .mode_sel(mode_sel), .auto_cycle(auto_cycle),
        .hsync(hsync_b), .vsync(vsync_b), .rgb(rgb_b), .mode_active(mode_b), .frame_count(fc_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: auto mode = (start_mode + frames_in_run / FPM) mod 6.
    int cb_of[2]  = '{1, 3};
    int fpm_of[2] = '{120, 2};
    int m_mode[2], m_cnt[2], m_k[2], m_m0[2];
    bit m_auto[2];
    int exp_rgb[2];

    function automatic int pix(input int cb, input int h, input int v, input int mode, input int cnt);
        int f, r, g, b, idx, hh;
        f = (1 << cb) - 1;
        r = 0; g = 0; b = 0;
        case (mode)
            0: begin
                if (h % 8 == 0 || v % 8 == 0) r = f;
                if ((v / 16) % 2 == 1) g = f;
                if ((h / 16) % 2 == 1) b = f;
            end
            1: begin
                idx = (h / 32) % 8;
                if (idx % 2 == 1) r = f;
                if ((idx / 2) % 2 == 1) g = f;
                if (idx / 4 == 1) b = f;
            end
            2: if (((h / 16) + (v / 16)) % 2 == 1) begin r = f; g = f; b = f; end
            3: begin
                r = h / (1 << (9 - cb));
                g = v / (1 << (9 - cb));
                b = cnt % (1 << cb);
            end
            4: begin
                hh = (h + cnt) % 512;
                if (((hh / 16) + (v / 16)) % 2 == 1) begin r = f; g = f; b = f; end
            end
            5: begin r = f; g = f; b = f; end
            default: ;
        endcase
        return b * (1 << (2 * cb)) + g * (1 << cb) + r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_cnt[i] = 0; m_k[i] = 0; m_m0[i] = 0; m_auto[i] = 1'b0;
        end
    endtask

    task automatic step(input int h, input int v, input bit don, input bit hs, input bit vs,
                        input int sel, input bit au);
        hpos = 9'(h); vpos = 9'(v); display_on = don;
        hsync_in = hs; vsync_in = vs; mode_sel = 3'(sel); auto_cycle = au;
        if (h == 0 && v == 0) begin
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = (m_cnt[i] + 1) % 256;
                if (au) begin
                    if (!m_auto[i]) begin
                        m_m0[i] = (m_mode[i] > 5) ? 0 : m_mode[i];
                        m_k[i]  = 0;
                    end else begin
                        m_k[i]++;
                    end
                    m_mode[i] = (m_m0[i] + m_k[i] / fpm_of[i]) % 6;
                end else begin
                    m_mode[i] = sel;
                end
                m_auto[i] = au;
            end
        end
        for (int i = 0; i < 2; i++)
            exp_rgb[i] = don ? pix(cb_of[i], h, v, m_mode[i], m_cnt[i]) : 0;
        @(posedge clk);
        #1;
        check("hsync_a", int'(hsync_a), int'(hs));
        check("vsync_a", int'(vsync_a), int'(vs));
        check("hsync_b", int'(hsync_b), int'(hs));
        check("vsync_b", int'(vsync_b), int'(vs));
        check("rgb_a", int'(rgb_a), exp_rgb[0]);
        check("rgb_b", int'(rgb_b), exp_rgb[1]);
        check("mode_a", int'(mode_a), m_mode[0]);
        check("mode_b", int'(mode_b), m_mode[1]);
        check("fc_a", int'(fc_a), m_cnt[0]);
        check("fc_b", int'(fc_b), m_cnt[1]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rgb_a"}, int'(rgb_a), 0);
        check({tag, "_rgb_b"}, int'(rgb_b), 0);
        check({tag, "_hs_a"}, int'(hsync_a), 0);
        check({tag, "_vs_b"}, int'(vsync_b), 0);
        check({tag, "_mode_a"}, int'(mode_a), 0);
        check({tag, "_mode_b"}, int'(mode_b), 0);
        check({tag, "_fc_a"}, int'(fc_a), 0);
        check({tag, "_fc_b"}, int'(fc_b), 0);
    endtask

    // Asserts reset between clock edges and checks outputs clear immediately.
    task automatic do_reset(input string tag);
        #3;
        reset = 1'b0;
        #1;
        check_all_zero(tag);
        model_reset();
        @(posedge clk);
        #1;
        check_all_zero({tag, "_held"});
        reset = 1'b1;
    endtask

    int auto_exp[6] = '{4, 4, 5, 5, 0, 0};
    int sel_r;
    bit au_r;

    initial begin
        reset = 1'b0;
        hpos = '0; vpos = '0; display_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        mode_sel = 3'd0; auto_cycle = 1'b0;
        model_reset();
        #1;
        check_all_zero("por");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Basic frame start, then GRID pixels with sync lag.
        step(0, 0, 1, 0, 0, 3, 0);
        check("t1_fc_a", int'(fc_a), 1);
        check("t1_mode_a", int'(mode_a), 3);
        step(0, 0, 1, 0, 0, 0, 0);
        step(8, 0, 1, 1, 0, 0, 0);
        check("t2_grid_8_0", int'(rgb_a), 1);
        check("t2_hsync_lag", int'(hsync_a), 1);
        step(16, 16, 1, 0, 1, 0, 0);
        check("t2_grid_16_16", int'(rgb_a), 7);
        step(16, 16, 0, 0, 0, 0, 0);
        check("t2_blank", int'(rgb_a), 0);

        // Mid-frame reset clears everything.
        step(40, 70, 1, 1, 1, 0, 0);
        do_reset("rst_mid");
        step(0, 0, 1, 0, 0, 2, 0);
        check("t1_after_rst_fc", int'(fc_a), 1);
        check("t1_after_rst_mode", int'(mode_b), 2);

        // Manual mode change mid-frame takes effect only at next frame.
        step(0, 50, 1, 0, 0, 2, 0);
        step(0, 100, 1, 0, 0, 5, 0);
        check("t3_mid_frame", int'(rgb_a), 0);
        step(0, 0, 1, 0, 0, 5, 0);
        check("t3_next_white", int'(rgb_a), 7);
        check("t3_mode", int'(mode_a), 5);

        // Auto cycling from mode 4 with two frames per mode.
        step(0, 0, 1, 0, 0, 4, 0);
        for (int f = 0; f < 6; f++) begin
            step(0, 0, 1, 0, 0, $urandom_range(0, 7), 1);
            check("t4_auto_mode_b", int'(mode_b), auto_exp[f]);
            step($urandom_range(1, 511), $urandom_range(0, 511), 1, 0, 0, $urandom_range(0, 7), 1);
        end

        // 256+ frames in SCROLL: count wraps, checker slides one pixel per frame.
        for (int f = 0; f < 260; f++) begin
            step(0, 0, 1, 0, 0, 4, 0);
            step($urandom_range(1, 511), 0, 1, 0, 0, 4, 0);
        end

        // GRAD with COLOR_BITS=3 at frame_count 5.
        do_reset("rst_grad");
        for (int f = 0; f < 5; f++) step(0, 0, 1, 0, 0, 3, 0);
        step(9'h1C0, 9'h040, 1, 0, 0, 3, 0);
        check("t6_grad_rgb_b", int'(rgb_b), 9'b101_001_111);

        // Randomised traffic: mid-frame input churn, reserved modes, auto toggling.
        au_r = 1'b0;
        sel_r = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) au_r = ~au_r;
            if ($urandom_range(0, 9) == 0) sel_r = $urandom_range(0, 7);
            if ($urandom_range(0, 7) == 0)
                step(0, 0, 1'($urandom), 1'($urandom), 1'($urandom), sel_r, au_r);
            else
                step($urandom_range(0, 511), $urandom_range(1, 511), 1'($urandom),
                     1'($urandom), 1'($urandom), sel_r, au_r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
